ahb_arbiter: RTL

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_pkg.sv | 21 ++
 rtl/ahb_rr_arbiter.sv | 26 ++
 rtl/ahb_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg
//   Shared AHB definitions used by the arbiter and by any slave model:
//   default bus widths, HTRANS encodings and a small one-hot helper.
package ahb_pkg;

    localparam int AHB_ADDR_W = 8;
    localparam int AHB_DATA_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // One-hot encode a requester index (0 -> 2'b01, 1 -> 2'b10).
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter
//   Two-way round-robin grant selection. Purely combinational.
//   Ports:
//     req_i        [1:0] per-requester request
//     last_grant_i       index of the requester granted most recently
//     grant_o      [1:0] one-hot grant (all zero when nobody requests)
module ahb_rr_arbiter
    import ahb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            // Both asking: hand the bus to whoever did not have it last.
            2'b11:   grant_o = onehot2(~last_grant_i);
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter
//   Funnels two simple request/ack clients onto one AHB master port with
//   round-robin arbitration and a pipelined address/data phase, giving one
//   transfer per cycle when the slave keeps hready high.
//   Ports:
//     hclk, hresetn            clock, asynchronous active-low reset
//     req[1:0]                 requests, held until ack
//     addr0/1, write0/1,       per-requester address, direction (1 = write)
//     wdata0/1                 and write data
//     ack[1:0]                 combinational accept strobe
//     done[1:0]                one-cycle pulse when the data phase completes
//     rdata0/1                 read data, updated with done, held otherwise
//     hselx, hwrite, htrans,   AHB master outputs
//     haddr, hwdata
//     hready, hrdata           AHB slave response
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int addrWidth = AHB_ADDR_W,
    parameter int dataWidth = AHB_DATA_W
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [1:0]           req,
    input  logic [addrWidth-1:0] addr0,
    input  logic [addrWidth-1:0] addr1,
    input  logic                 write0,
    input  logic                 write1,
    input  logic [dataWidth-1:0] wdata0,
    input  logic [dataWidth-1:0] wdata1,
    output logic [1:0]           ack,
    output logic [1:0]           done,
    output logic [dataWidth-1:0] rdata0,
    output logic [dataWidth-1:0] rdata1,
    output logic                 hselx,
    output logic                 hwrite,
    output logic [1:0]           htrans,
    output logic [addrWidth-1:0] haddr,
    output logic [dataWidth-1:0] hwdata,
    input  logic                 hready,
    input  logic [dataWidth-1:0] hrdata
);

    logic [1:0] grant;

    // Address-phase state (bus outputs double as the address-phase record)
    htrans_e              htrans_q, htrans_d;
    logic                 hselx_q,  hselx_d;
    logic [addrWidth-1:0] haddr_q,  haddr_d;
    logic                 hwrite_q, hwrite_d;
    logic                 ap_id_q,  ap_id_d;
    logic [dataWidth-1:0] ap_wdata_q;

    // Data-phase state
    logic                 dp_vld_q,   dp_vld_d;
    logic                 dp_id_q,    dp_id_d;
    logic                 dp_write_q, dp_write_d;
    logic [dataWidth-1:0] hwdata_q,   hwdata_d;

    // Completion and arbitration history
    logic [1:0]           done_q,   done_d;
    logic [dataWidth-1:0] rdata0_q, rdata0_d;
    logic [dataWidth-1:0] rdata1_q, rdata1_d;
    logic                 last_q,   last_d;

    ahb_rr_arbiter u_rr (
        .req_i        (req),
        .last_grant_i (last_q),
        .grant_o      (grant)
    );

    // A request can only be consumed when the bus is advancing.
    assign ack = grant & {2{hready}};

    always_comb begin
        htrans_d   = htrans_q;
        hselx_d    = hselx_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        ap_id_d    = ap_id_q;
        dp_vld_d   = dp_vld_q;
        dp_id_d    = dp_id_q;
        dp_write_d = dp_write_q;
        hwdata_d   = hwdata_q;
        done_d     = 2'b00;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        last_d     = last_q;

        // With hready low every stage simply holds.
        if (hready) begin
            // Retire the data phase
            if (dp_vld_q) begin
                done_d[dp_id_q] = 1'b1;
                if (!dp_write_q) begin
                    if (dp_id_q) rdata1_d = hrdata;
                    else         rdata0_d = hrdata;
                end
            end

            // Advance address phase into data phase
            dp_vld_d = (htrans_q == HTRANS_NONSEQ);
            if (htrans_q == HTRANS_NONSEQ) begin
                dp_id_d    = ap_id_q;
                dp_write_d = hwrite_q;
                hwdata_d   = ap_wdata_q;
            end

            // Launch a new address phase, or go idle keeping haddr/hwrite
            if (|ack) begin
                htrans_d = HTRANS_NONSEQ;
                hselx_d  = 1'b1;
                ap_id_d  = ack[1];
                haddr_d  = ack[1] ? addr1  : addr0;
                hwrite_d = ack[1] ? write1 : write0;
                last_d   = ack[1];
            end else begin
                htrans_d = HTRANS_IDLE;
                hselx_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            htrans_q   <= HTRANS_IDLE;
            hselx_q    <= 1'b0;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            ap_id_q    <= 1'b0;
            dp_vld_q   <= 1'b0;
            dp_id_q    <= 1'b0;
            dp_write_q <= 1'b0;
            hwdata_q   <= '0;
            done_q     <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            last_q     <= 1'b1;  // requester 0 wins the first contention
        end else begin
            htrans_q   <= htrans_d;
            hselx_q    <= hselx_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            ap_id_q    <= ap_id_d;
            dp_vld_q   <= dp_vld_d;
            dp_id_q    <= dp_id_d;
            dp_write_q <= dp_write_d;
            hwdata_q   <= hwdata_d;
            done_q     <= done_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            last_q     <= last_d;
        end
    end

    // Write data parked for the address phase; only meaningful while a
    // NONSEQ is outstanding, so it carries no reset.
    always_ff @(posedge hclk) begin
        if (|ack) ap_wdata_q <= ack[1] ? wdata1 : wdata0;
    end

    assign htrans = htrans_q;
    assign hselx  = hselx_q;
    assign haddr  = haddr_q;
    assign hwrite = hwrite_q;
    assign hwdata = hwdata_q;
    assign done   = done_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule
